// File: rtl/des3_stream_ctrl.sv
// des3_stream_ctrl: valid/ready front end for the des3 core.
// Accepts key1, key2, key3, data words, strips key parity bits, waits out
// the des3 latency, captures des_out and presents it on a result stream.
// Optional macro DES3_PARITY_CHK_EN adds a sticky odd-parity error flag (key_err).
module des3_stream_ctrl #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_word,
  input  logic        in_decrypt,
  input  logic        keep_key,
  output logic [55:0] key1,
  output logic [55:0] key2,
  output logic [55:0] key3,
  output logic [63:0] des_in,
  output logic        decrypt,
  input  logic [63:0] des_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
`ifdef DES3_PARITY_CHK_EN
  output logic        key_err,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    LD_K1,
    LD_K2,
    LD_K3,
    LD_DATA,
    RUN,
    OUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Keep the upper seven bits of every byte, MSB byte first.
  function automatic logic [55:0] strip_parity(input logic [63:0] w);
    logic [55:0] k;
    k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k[7*i +: 7] = w[8*i+1 +: 7];
    end
    return k;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LD_K1;
    else       state <= state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != LD_K1);
    case (state)
      LD_K1: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = LD_K2;
      end
      LD_K2: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = LD_K3;
      end
      LD_K3: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = LD_DATA;
      end
      LD_DATA: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) state_nx = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = keep_key ? LD_DATA : LD_K1;
      end
      default: state_nx = LD_K1;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Datapath: only the register addressed by the current load state is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      key1     <= '0;
      key2     <= '0;
      key3     <= '0;
      des_in   <= '0;
      decrypt  <= 1'b0;
      res_data <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        case (state)
          LD_K1:   key1 <= strip_parity(in_word);
          LD_K2:   key2 <= strip_parity(in_word);
          LD_K3:   key3 <= strip_parity(in_word);
          LD_DATA: begin
            des_in  <= in_word;
            decrypt <= in_decrypt;
            cnt     <= '0;
          end
          default: ;
        endcase
      end
      if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) res_data <= des_out;
      end
    end
  end

`ifdef DES3_PARITY_CHK_EN
  logic par_bad;

  // Any byte with an even number of ones is a parity error.
  always_comb begin
    par_bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (~^in_word[8*i +: 8]) par_bad = 1'b1;
    end
  end

  // Sticky flag: a fresh key1 restarts the check, key2/key3 can only set it.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_err <= 1'b0;
    end else if (accept) begin
      case (state)
        LD_K1:        key_err <= par_bad;
        LD_K2, LD_K3: key_err <= key_err | par_bad;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_des3_stream_ctrl.sv
// Bench for des3_stream_ctrl: two instances (LATENCY 1 and 4), each driving
// a stub des3 model that only produces its result LATENCY cycles after its
// inputs settle. Results are scoreboarded; a vector table covers full loads.
module tb_des3_stream_ctrl;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [63:0] in_word    [2];
  logic        in_decrypt [2];
  logic        keep_key   [2];
  logic [55:0] key1       [2];
  logic [55:0] key2       [2];
  logic [55:0] key3       [2];
  logic [63:0] des_in     [2];
  logic        decrypt    [2];
  logic [63:0] des_out    [2];
  logic        res_valid  [2];
  logic        res_ready  [2];
  logic [63:0] res_data   [2];
  logic        busy       [2];
`ifdef DES3_PARITY_CHK_EN
  logic        key_err    [2];
`endif

  int n_chk    = 0;
  int n_fail   = 0;
  int rv1_seen = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  // Stub des3: the two single-DES known-answer pairs for the all-zero key,
  // otherwise an arbitrary mix of every input so any wrong input shows up.
  function automatic logic [63:0] des_stub(input logic [55:0] a, input logic [55:0] b,
                                           input logic [55:0] c, input logic [63:0] d,
                                           input logic dec);
    if (a == '0 && b == '0 && c == '0 && !dec && d == 64'h95F8A5E5DD31D900)
      return 64'h8000000000000000;
    if (a == '0 && b == '0 && c == '0 && dec && d == 64'h8000000000000000)
      return 64'h95F8A5E5DD31D900;
    return d ^ {a, 8'h3C} ^ {8'hC3, b} ^ {c[31:0], c[55:24]} ^ {64{dec}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int unsigned L   = (g == 0) ? LAT0 : LAT1;
    localparam int unsigned IDX = (L >= 2) ? L - 2 : 0;
    logic [63:0] f_now;
    logic [63:0] dly [L];

    always_comb f_now = des_stub(key1[g], key2[g], key3[g], des_in[g], decrypt[g]);

    always @(posedge clk) begin
      dly[0] <= f_now;
      for (int i = 1; i < int'(L); i++) dly[i] <= dly[i-1];
    end

    assign des_out[g] = (L == 1) ? f_now : dly[IDX];

    des3_stream_ctrl #(.LATENCY(L), .CNT_W(8)) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_word    (in_word[g]),
      .in_decrypt (in_decrypt[g]),
      .keep_key   (keep_key[g]),
      .key1       (key1[g]),
      .key2       (key2[g]),
      .key3       (key3[g]),
      .des_in     (des_in[g]),
      .decrypt    (decrypt[g]),
      .des_out    (des_out[g]),
      .res_valid  (res_valid[g]),
      .res_ready  (res_ready[g]),
      .res_data   (res_data[g]),
`ifdef DES3_PARITY_CHK_EN
      .key_err    (key_err[g]),
`endif
      .busy       (busy[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int g, input logic [63:0] v);
    if (g == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Result monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    #1;
    if (res_valid[1]) rv1_seen++;
    for (int g = 0; g < 2; g++) begin
      if (res_valid[g] && res_ready[g]) begin
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: inst %0d produced %h with nothing expected", g, res_data[g]);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("sb_result", res_data[g], e);
        end
      end
    end
  end

  // Offer one word at a negedge; returns at the negedge after it was taken.
  task automatic put(input int g, input logic [63:0] w, input logic dec);
    int n;
    n = 0;
    in_valid[g] = 1'b1;
    in_word[g] = w;
    in_decrypt[g] = dec;
    while (!in_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL put_timeout: in_ready was 0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    in_valid[g] = 1'b0;
    in_word[g] = ~w;
    in_decrypt[g] = ~dec;
  endtask

  task automatic load_keys(input int g, input logic [63:0] k1, input logic [63:0] k2,
                           input logic [63:0] k3, input int gap);
    put(g, k1, 1'b0);
    repeat (gap) @(negedge clk);
    put(g, k2, 1'b1);
    repeat (gap) @(negedge clk);
    put(g, k3, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  // Send the data word, then follow RUN until res_valid rises.
  task automatic run_block(input int g, input int unsigned lat, input logic [63:0] data,
                           input logic dec, input logic [55:0] e1, input logic [55:0] e2,
                           input logic [55:0] e3, input bit junk);
    int n;
    sb_push(g, des_stub(e1, e2, e3, data, dec));
    put(g, data, dec);
    chk("key1", key1[g], e1);
    chk("key2", key2[g], e2);
    chk("key3", key3[g], e3);
    chk("des_in", des_in[g], data);
    chk("decrypt", decrypt[g], dec);
    n = 0;
    while (!res_valid[g] && n < 40) begin
      chk("in_ready_run", in_ready[g], 0);
      chk("decrypt_run", decrypt[g], dec);
      if (junk) begin
        in_valid[g] = 1'b1;
        in_word[g] = {$urandom, $urandom};
      end
      @(negedge clk);
      n++;
    end
    in_valid[g] = 1'b0;
    chk("latency", n, lat);
    chk("des_in_hold", des_in[g], data);
  endtask

  task automatic finish_hs(input int g);
    int n;
    n = 0;
    while (!(res_valid[g] && res_ready[g]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL hs_timeout: no result handshake within %0d cycles", n);
    end
    @(negedge clk);
    chk("res_valid_drop", res_valid[g], 0);
  endtask

  task automatic check_idle(input int g);
    chk("idle_key1", key1[g], 0);
    chk("idle_key2", key2[g], 0);
    chk("idle_key3", key3[g], 0);
    chk("idle_des_in", des_in[g], 0);
    chk("idle_decrypt", decrypt[g], 0);
    chk("idle_res_data", res_data[g], 0);
    chk("idle_res_valid", res_valid[g], 0);
    chk("idle_busy", busy[g], 0);
    chk("idle_in_ready", in_ready[g], 1);
`ifdef DES3_PARITY_CHK_EN
    chk("idle_key_err", key_err[g], 0);
`endif
  endtask

  typedef struct {
    logic [63:0] k1, k2, k3, data;
    logic        dec;
    logic [55:0] e1, e2, e3;
    logic [63:0] eres;
    bit          has_eres;
    int          gap;
  } vec_t;

  vec_t vecs [4];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h0101010101010101, 64'h0101010101010101, 64'h0101010101010101,
                64'h95F8A5E5DD31D900, 1'b0, 56'h0, 56'h0, 56'h0,
                64'h8000000000000000, 1'b1, 0};
    vecs[1] = '{64'h0101010101010101, 64'h0101010101010101, 64'h0101010101010101,
                64'h8000000000000000, 1'b1, 56'h0, 56'h0, 56'h0,
                64'h95F8A5E5DD31D900, 1'b1, 0};
    vecs[2] = '{64'hFEFEFEFEFEFEFEFE, 64'h0123456789ABCDEF, 64'h0101010101010101,
                64'h0011223344556677, 1'b0, 56'hFFFFFFFFFFFFFF, 56'h00451338957377, 56'h0,
                64'h0, 1'b0, 2};
    vecs[3] = '{64'h0123456789ABCDEF, 64'hFEFEFEFEFEFEFEFE, 64'h0123456789ABCDEF,
                64'hA5A5A5A55A5A5A5A, 1'b1, 56'h00451338957377, 56'hFFFFFFFFFFFFFF,
                56'h00451338957377, 64'h0, 1'b0, 1};

    for (int g = 0; g < 2; g++) begin
      reset[g] = 1'b1;
      in_valid[g] = 1'b0;
      in_word[g] = '0;
      in_decrypt[g] = 1'b0;
      keep_key[g] = 1'b0;
      res_ready[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_idle(0);
    check_idle(1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready[0], 1);

    // Full loads from the table; gapped entries also poke junk during RUN.
    for (int i = 0; i < 4; i++) begin
      load_keys(0, vecs[i].k1, vecs[i].k2, vecs[i].k3, vecs[i].gap);
      repeat (vecs[i].gap) @(negedge clk);
      run_block(0, LAT0, vecs[i].data, vecs[i].dec, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                vecs[i].gap > 0);
      if (vecs[i].has_eres) chk("kat_res", res_data[0], vecs[i].eres);
      finish_hs(0);
      chk("back_to_k1", busy[0], 0);
    end

    // Backpressure with key reuse.
    begin : stall
      logic [63:0] exp;
      exp = des_stub(56'h00451338957377, 56'hFFFFFFFFFFFFFF, 56'h0, 64'h0F1E2D3C4B5A6978, 1'b0);
      keep_key[0] = 1'b1;
      res_ready[0] = 1'b0;
      load_keys(0, 64'h0123456789ABCDEF, 64'hFEFEFEFEFEFEFEFE, 64'h0101010101010101, 0);
      run_block(0, LAT0, 64'h0F1E2D3C4B5A6978, 1'b0,
                56'h00451338957377, 56'hFFFFFFFFFFFFFF, 56'h0, 1'b0);
      repeat (5) begin
        @(negedge clk);
        chk("stall_valid", res_valid[0], 1);
        chk("stall_data", res_data[0], exp);
      end
      res_ready[0] = 1'b1;
      finish_hs(0);
      keep_key[0] = 1'b0;
      chk("reuse_busy", busy[0], 1);
      chk("reuse_in_ready", in_ready[0], 1);
      run_block(0, LAT0, 64'hDEADBEEF01234567, 1'b1,
                56'h00451338957377, 56'hFFFFFFFFFFFFFF, 56'h0, 1'b0);
      finish_hs(0);
      chk("reuse_back_to_k1", busy[0], 0);
    end

    // Reset wins over a key1 handshake in the same cycle.
    in_valid[0] = 1'b1;
    in_word[0] = 64'hFEFEFEFEFEFEFEFE;
    reset[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    reset[0] = 1'b0;
    check_idle(0);

    // Reset two cycles after the data handshake, LATENCY 4.
    load_keys(1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hFEFEFEFEFEFEFEFE, 0);
    put(1, 64'h1122334455667788, 1'b1);
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    check_idle(1);
    repeat (6) @(negedge clk);
    chk("abort_no_result", rv1_seen, 0);
    load_keys(1, 64'h0123456789ABCDEF, 64'hFEFEFEFEFEFEFEFE, 64'h0101010101010101, 1);
    run_block(1, LAT1, 64'h1122334455667788, 1'b1,
              56'h00451338957377, 56'hFFFFFFFFFFFFFF, 56'h0, 1'b1);
    finish_hs(1);

`ifdef DES3_PARITY_CHK_EN
    put(0, 64'h0123456789ABCDEF, 1'b0);
    chk("key_err_clean", key_err[0], 0);
    put(0, 64'h0001010101010101, 1'b0);
    chk("key_err_rise", key_err[0], 1);
    put(0, 64'h0123456789ABCDEF, 1'b0);
    run_block(0, LAT0, 64'h0123012301230123, 1'b0,
              56'h00451338957377, 56'h0, 56'h00451338957377, 1'b0);
    chk("key_err_out", key_err[0], 1);
    finish_hs(0);
    chk("key_err_hold", key_err[0], 1);
    put(0, 64'h0123456789ABCDEF, 1'b0);
    chk("key_err_clear", key_err[0], 0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty0", q0.size(), 0);
    chk("sb_empty1", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
